// File: rtl/serial_deframer.sv
`default_nettype none
// serial_deframer: hunts an LSB-first bit stream for SYNC, packs FRAME_LEN payload bytes into a show-ahead FIFO.
// Optional macro DEFRAMER_SYNC_TOL_EN: sync accepted within Hamming distance 1, adds sync_corrected pulse output.
module serial_deframer #(
  parameter logic [7:0] SYNC       = 8'h7E,
  parameter int         FRAME_LEN  = 4,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_bit,
  input  logic       hunt,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       m_first,
  output logic       m_last,
  output logic       locked,
  output logic       overflow
`ifdef DEFRAMER_SYNC_TOL_EN
  ,
  output logic       sync_corrected
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    S_HUNT    = 1'b0,
    S_PAYLOAD = 1'b1
  } state_t;

  state_t          state_q;
  logic            locked_q;
  logic [7:0]      window_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      byte_cnt_q;
  logic            overflow_q;

  logic [7:0]      fifo_data_q  [FIFO_DEPTH];
  logic            fifo_first_q [FIFO_DEPTH];
  logic            fifo_last_q  [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;

  logic [7:0]      window_next;
  logic [7:0]      sync_diff;
  logic            sync_exact;
  logic            sync_hit;
  logic            push_req;
  logic            push_first;
  logic            push_last;
  logic            fifo_full;
  logic            pop;
  logic            push_ok;

  assign window_next = {in_bit, window_q[7:1]};
  assign sync_diff   = window_next ^ SYNC;
  assign sync_exact  = (sync_diff == 8'h00);

`ifdef DEFRAMER_SYNC_TOL_EN
  logic sync_corr_q;
  // x & (x-1) clears the lowest set bit, so zero means at most one differing bit.
  assign sync_hit       = ((sync_diff & 8'(sync_diff - 8'd1)) == 8'h00);
  assign sync_corrected = sync_corr_q;
`else
  assign sync_hit = sync_exact;
`endif

  assign push_req   = (state_q == S_PAYLOAD) && in_valid && !hunt && (bit_cnt_q == 3'd7);
  assign push_first = (byte_cnt_q == 8'd0);
  assign push_last  = (byte_cnt_q == 8'(FRAME_LEN - 1));

  assign m_valid   = (count_q != '0);
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign pop       = m_valid && m_ready;
  assign push_ok   = push_req && (!fifo_full || pop);

  assign m_data   = m_valid ? fifo_data_q[rd_ptr_q]  : 8'h00;
  assign m_first  = m_valid ? fifo_first_q[rd_ptr_q] : 1'b0;
  assign m_last   = m_valid ? fifo_last_q[rd_ptr_q]  : 1'b0;
  assign locked   = locked_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_HUNT;
      locked_q   <= 1'b0;
      window_q   <= 8'h00;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
`ifdef DEFRAMER_SYNC_TOL_EN
      sync_corr_q <= 1'b0;
`endif
    end else begin
`ifdef DEFRAMER_SYNC_TOL_EN
      sync_corr_q <= 1'b0;
`endif
      if (hunt) begin
        state_q    <= S_HUNT;
        locked_q   <= 1'b0;
        window_q   <= 8'h00;
        bit_cnt_q  <= 3'd0;
        byte_cnt_q <= 8'd0;
      end else if (in_valid) begin
        case (state_q)
          S_HUNT: begin
            if (sync_hit) begin
              state_q    <= S_PAYLOAD;
              locked_q   <= 1'b1;
              window_q   <= 8'h00;
              bit_cnt_q  <= 3'd0;
              byte_cnt_q <= 8'd0;
`ifdef DEFRAMER_SYNC_TOL_EN
              sync_corr_q <= !sync_exact;
`endif
            end else begin
              window_q <= window_next;
            end
          end
          S_PAYLOAD: begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7 && push_last) begin
              // Frame complete: the next frame must present a whole new sync byte.
              state_q    <= S_HUNT;
              locked_q   <= 1'b0;
              window_q   <= 8'h00;
              byte_cnt_q <= 8'd0;
            end else begin
              window_q <= window_next;
              if (bit_cnt_q == 3'd7) begin
                byte_cnt_q <= byte_cnt_q + 8'd1;
              end
            end
          end
          default: begin
            state_q  <= S_HUNT;
            locked_q <= 1'b0;
          end
        endcase
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // A dropped byte still advances the frame counters; only this flag records it.
      if (push_req && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_data_q[wr_ptr_q]  <= window_next;
      fifo_first_q[wr_ptr_q] <= push_first;
      fifo_last_q[wr_ptr_q]  <= push_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_deframer.sv
`default_nettype none
// tb_serial_deframer: two deframers (FRAME_LEN 4 and 6, FIFO_DEPTH 4) on one shared stimulus,
// each compared against a bit-level reference model and an expected-byte scoreboard.
module tb_serial_deframer;

  localparam logic [7:0] SYNC  = 8'h7E;
  localparam int         DEPTH = 4;

  logic clk      = 1'b0;
  logic reset    = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit   = 1'b0;
  logic hunt     = 1'b0;
  logic m_ready  = 1'b0;
  logic done     = 1'b0;

  logic [7:0] mdata   [2];
  logic       mvalid  [2];
  logic       mfirst  [2];
  logic       mlast   [2];
  logic       mlocked [2];
  logic       movfl   [2];

  always #5 clk = ~clk;

  serial_deframer #(.SYNC(SYNC), .FRAME_LEN(4), .FIFO_DEPTH(DEPTH)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .hunt(hunt),
    .m_data(mdata[0]), .m_valid(mvalid[0]), .m_ready(m_ready), .m_first(mfirst[0]),
    .m_last(mlast[0]), .locked(mlocked[0]), .overflow(movfl[0])
  );

  serial_deframer #(.SYNC(SYNC), .FRAME_LEN(6), .FIFO_DEPTH(DEPTH)) u_dut6 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit), .hunt(hunt),
    .m_data(mdata[1]), .m_valid(mvalid[1]), .m_ready(m_ready), .m_first(mfirst[1]),
    .m_last(mlast[1]), .locked(mlocked[1]), .overflow(movfl[1])
  );

  typedef struct packed {
    logic [7:0] d;
    logic       f;
    logic       l;
  } ent_t;

  // Reference model state, one set per instance.
  int         flen   [2] = '{4, 6};
  bit         mlock  [2];
  logic [7:0] hist   [2];
  logic [7:0] acc    [2];
  int         nbits  [2];
  int         nbytes [2];
  int         mcnt   [2];
  bit         movf   [2];
  ent_t       sb0[$];
  ent_t       sb1[$];

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
    end
  endfunction

  function automatic void sb_push(int k, ent_t e);
    if (k == 0) sb0.push_back(e); else sb1.push_back(e);
  endfunction
  function automatic int sb_size(int k);
    return (k == 0) ? sb0.size() : sb1.size();
  endfunction
  function automatic ent_t sb_front(int k);
    return (k == 0) ? sb0[0] : sb1[0];
  endfunction
  function automatic void sb_pop(int k);
    if (k == 0) void'(sb0.pop_front()); else void'(sb1.pop_front());
  endfunction

  function automatic void model_clear(int k);
    mlock[k] = 0; hist[k] = 8'h00; acc[k] = 8'h00;
    nbits[k] = 0; nbytes[k] = 0; mcnt[k] = 0; movf[k] = 0;
    if (k == 0) sb0.delete(); else sb1.delete();
  endfunction

  // Effect of the coming rising edge given the inputs currently applied.
  function automatic void model_step(int k);
    bit   pop_now;
    bit   push_now;
    ent_t e;
    pop_now  = (mcnt[k] > 0) && m_ready;
    push_now = 0;
    e        = '0;
    if (hunt) begin
      mlock[k] = 0; hist[k] = 8'h00; acc[k] = 8'h00; nbits[k] = 0; nbytes[k] = 0;
    end else if (in_valid) begin
      if (!mlock[k]) begin
        hist[k] = {in_bit, hist[k][7:1]};
        if (hist[k] == SYNC) begin
          mlock[k] = 1; hist[k] = 8'h00; acc[k] = 8'h00; nbits[k] = 0; nbytes[k] = 0;
        end
      end else begin
        acc[k][nbits[k]] = in_bit;
        nbits[k]++;
        if (nbits[k] == 8) begin
          e.d = acc[k];
          e.f = (nbytes[k] == 0);
          e.l = (nbytes[k] == flen[k] - 1);
          push_now = 1;
          nbytes[k]++;
          nbits[k] = 0;
          acc[k] = 8'h00;
          if (e.l) begin
            mlock[k] = 0; hist[k] = 8'h00; nbytes[k] = 0;
          end
        end
      end
    end
    if (push_now) begin
      if (mcnt[k] < DEPTH || pop_now) begin
        sb_push(k, e);
        mcnt[k]++;
      end else begin
        movf[k] = 1;
      end
    end
    if (pop_now) mcnt[k]--;
  endfunction

  // Monitor: compares DUT outputs with model/scoreboard, pops on each DUT handshake.
  initial begin
    ent_t e;
    forever begin
      @(negedge clk or negedge reset);
      if (!reset) begin
        #1;
        for (int k = 0; k < 2; k++) begin
          chk("rst_m_valid", k, 32'(mvalid[k]), 32'd0);
          chk("rst_m_data", k, 32'(mdata[k]), 32'd0);
          chk("rst_m_first", k, 32'(mfirst[k]), 32'd0);
          chk("rst_m_last", k, 32'(mlast[k]), 32'd0);
          chk("rst_locked", k, 32'(mlocked[k]), 32'd0);
          chk("rst_overflow", k, 32'(movfl[k]), 32'd0);
          model_clear(k);
        end
      end else if (done) begin
        for (int k = 0; k < 2; k++) begin
          chk("leftover_expected", k, 32'(sb_size(k)), 32'd0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end else begin
        for (int k = 0; k < 2; k++) begin
          chk("locked", k, 32'(mlocked[k]), 32'(mlock[k]));
          chk("overflow", k, 32'(movfl[k]), 32'(movf[k]));
          chk("m_valid", k, 32'(mvalid[k]), 32'(mcnt[k] != 0));
          if (mvalid[k]) begin
            chk("byte_expected", k, 32'(sb_size(k) != 0), 32'd1);
            if (sb_size(k) != 0) begin
              e = sb_front(k);
              chk("m_data", k, 32'(mdata[k]), 32'(e.d));
              chk("m_first", k, 32'(mfirst[k]), 32'(e.f));
              chk("m_last", k, 32'(mlast[k]), 32'(e.l));
              if (m_ready) sb_pop(k);
            end
          end else begin
            chk("idle_m_data", k, 32'(mdata[k]), 32'd0);
          end
          model_step(k);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    in_valid = 1'b1;
    in_bit   = b;
    tick();
    in_valid = 1'b0;
    repeat (gap) begin
      in_bit = 1'($urandom);
      tick();
    end
  endtask

  task automatic send_byte(input logic [7:0] v, input int gap);
    for (int i = 0; i < 8; i++) send_bit(v[i], gap);
  endtask

  task automatic do_hunt();
    hunt     = 1'b1;
    in_valid = 1'b1;
    in_bit   = 1'($urandom);
    tick();
    hunt     = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    m_ready = 1'b1;
    repeat (n) tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] v;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // Lock and deliver 12 34 56 78 with the consumer always ready.
    m_ready = 1'b1;
    send_byte(SYNC, 0);
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
    do_hunt();
    drain(4);

    // Garbage prefix before sync.
    for (int i = 0; i < 5; i++) send_bit(1'($urandom), 0);
    send_byte(SYNC, 0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    do_hunt();
    drain(4);

    // Sparse bits: one valid bit every third cycle.
    send_byte(SYNC, 2);
    send_byte(8'h12, 2); send_byte(8'h34, 2); send_byte(8'h56, 2); send_byte(8'h78, 2);
    do_hunt();
    drain(4);

    // Backpressure through a whole 6-byte frame, then release.
    m_ready = 1'b0;
    send_byte(SYNC, 0);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 0);
    repeat (3) tick();
    drain(8);

    // Full FIFO with push and pop on the same edge.
    pulse_reset();
    m_ready = 1'b0;
    send_byte(SYNC, 0);
    for (int i = 0; i < 4; i++) send_byte(8'hA0 + 8'(i), 0);
    for (int j = 0; j < 2; j++) begin
      v = 8'hC3 + 8'(j);
      for (int i = 0; i < 8; i++) begin
        m_ready = (i == 7);
        send_bit(v[i], 0);
      end
    end
    m_ready = 1'b0;
    repeat (2) tick();
    drain(8);

    // hunt after 12 payload bits: first byte stays queued, no last marker.
    m_ready = 1'b0;
    send_byte(SYNC, 0);
    send_byte(8'h5A, 0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), 0);
    do_hunt();
    repeat (2) tick();
    drain(4);

    // Asynchronous reset in the middle of a frame with a byte pending.
    m_ready = 1'b0;
    send_byte(SYNC, 0);
    send_byte(8'h3C, 0);
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Random traffic with sync injections, random backpressure and rare hunts.
    for (int n = 0; n < 400; n++) begin
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        send_byte(SYNC, 0);
      end else if ($urandom_range(0, 99) == 0) begin
        do_hunt();
      end else begin
        in_valid = 1'($urandom);
        in_bit   = 1'($urandom);
        tick();
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    drain(10);

    done = 1'b1;
  end

endmodule
`default_nettype wire

// File: doc/serial_deframer.md
Name: serial_deframer

Overview:
Consumes the LSB-first serial bit stream produced by the 8-bit serial shift stage, one bit per qualified clock. Hunts for a sync byte, then assembles a fixed-length payload into bytes. Payload bytes are delivered through a small show-ahead FIFO with a valid/ready handshake to the downstream byte consumer, e.g. the SPI/USB bridge. Marks the first and last byte of each frame and flags overflow.

Parameters:
SYNC, 8'h7E, sync byte value in assembled byte order; bit 0 is received first.
FRAME_LEN, 4, payload bytes per frame after sync; legal range 1..255.
FIFO_DEPTH, 4, output FIFO entries; power of two, at least 2.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately
in_valid  input  1  in_bit is sampled on this cycle
in_bit  input  1  serial data bit from the shift stage, LSB-first
hunt  input  1  synchronous force back to HUNT state
m_data  output  8  FIFO head byte
m_valid  output  1  FIFO not empty
m_ready  input  1  consumer accepts the head byte when m_valid=1
m_first  output  1  head byte is the first payload byte of a frame
m_last  output  1  head byte is the last payload byte of a frame
locked  output  1  high while in PAYLOAD state
overflow  output  1  sticky; a payload byte was dropped because the FIFO was full

Behaviour:
- Reset (reset=0, asynchronous):
  - state=HUNT, window=8'h00, bit_cnt=0, byte_cnt=0.
  - FIFO emptied.
  - Outputs: m_valid=0, m_data=0, m_first=0, m_last=0, locked=0, overflow=0.
- Assembly window:
  - On each in_valid cycle: window_next = {in_bit, window[7:1]}.
  - Bits are never sampled when in_valid=0.
- HUNT state:
  - window updates on every in_valid.
  - If window_next == SYNC: go to PAYLOAD, clear bit_cnt and byte_cnt, clear window.
  - Sync matches may overlap arbitrarily with previous bits.
- PAYLOAD state:
  - bit_cnt increments on each in_valid.
  - On the 8th bit (bit_cnt==7): window_next is pushed to the FIFO with first=(byte_cnt==0) and last=(byte_cnt==FRAME_LEN-1).
  - On that push, bit_cnt wraps to 0 and byte_cnt increments.
  - After the push flagged last: return to HUNT with window cleared. The next frame needs a full sync byte.
  - No sync search occurs during PAYLOAD.
- Latency:
  - A byte whose 8th bit is sampled at edge N is visible on m_data/m_valid after edge N, provided the FIFO was empty.
  - locked rises after the edge that matched sync.
  - locked falls after the edge that pushed the last byte.
- FIFO:
  - Show-ahead: m_data/m_first/m_last always reflect the head entry. Values are undefined-but-stable when m_valid=0; drive them as 0 when empty.
  - Pop on m_valid && m_ready.
  - A push is accepted if count < FIFO_DEPTH, or if a pop happens in the same cycle (full plus simultaneous push and pop: both occur, count unchanged).
  - Push to a full FIFO with no pop: byte dropped, overflow set to 1 (sticky until reset). Frame counting continues as if the byte had been stored.
  - Pop when empty: ignored.
  - m_data must hold stable while m_valid=1 && m_ready=0.
- hunt=1:
  - Next state is HUNT. window, bit_cnt, and byte_cnt are cleared and any partial byte is discarded.
  - A bit presented in the same cycle is discarded; hunt wins over in_valid.
  - FIFO contents and overflow are unaffected.
  - A frame truncated this way has no m_last byte.
- Reset mid-frame: all partial state is lost, FIFO is emptied, and no pending byte is delivered.

Optional Feature:
Macro DEFRAMER_SYNC_TOL_EN.
- Defined: HUNT accepts window_next with Hamming distance ≤1 from SYNC, and adds output sync_corrected (1 bit). sync_corrected is a single-cycle pulse after an edge that locked on an inexact match. Reset value is 0.
- Undefined: exact match only, and the sync_corrected port is absent.

Test Plan:
- Lock and deliver: reset, m_ready=1. Stream bits 0,1,1,1,1,1,1,0 (0x7E), then bytes 0x12, 0x34, 0x56, 0x78 LSB-first.
  - Required: locked=1 after the 8th sync bit.
  - m_data sequence 0x12, 0x34, 0x56, 0x78.
  - m_first only on 0x12, m_last only on 0x78.
  - locked=0 after the last push.
- Hunt with garbage: 5 random bits followed by 0x7E and a frame.
  - Required: lock occurs exactly on the sync's 8th bit, and the payload is intact.
- Sparse bits: in_valid asserted every 3rd cycle, same frame as the first scenario.
  - Required: identical byte output.
  - No sampling occurs on idle cycles.
- Backpressure/overflow (FIFO_DEPTH=4, FRAME_LEN=6): m_ready=0 for a full frame 0x01..0x06.
  - Required: FIFO holds 0x01..0x04 and overflow=1.
  - 0x05 and 0x06 are dropped and locked returns to 0.
  - Then m_ready=1: pops 0x01..0x04, with m_data stable while stalled.
- Full with simultaneous push and pop: FIFO full, m_ready=1 on the push cycle.
  - Required: no overflow, and order is preserved.
- hunt and reset mid-frame:
  - hunt=1 after 12 payload bits: returns to HUNT, the earlier byte remains queued, and there is no m_last.
  - reset=0 mid-frame: all outputs return to 0 immediately (asynchronously).
